// File: rtl/serial_wide_adder_pkg.sv
// Shared types and helpers for the serial wide adder: FSM encoding,
// slice-index width and the two's-complement overflow rule.
package serial_wide_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slice counter width, never narrower than one bit.
  function automatic int idx_width(input int nchunks);
    return (nchunks > 1) ? $clog2(nchunks) : 1;
  endfunction

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/lpm_add_sub.sv
// Behavioural model of the codebase's lpm_add_sub chunk adder primitive
// (combinational, add_sub=1 subtracts, aclr/clken gate the outputs).
module lpm_add_sub #(
  parameter int lpm_width = 8
) (
  input  logic [lpm_width-1:0] dataa,
  input  logic [lpm_width-1:0] datab,
  input  logic                 cin,
  input  logic                 add_sub,
  input  logic                 clken,
  input  logic                 aclr,
  output logic [lpm_width-1:0] result,
  output logic                 cout,
  output logic                 overflow
);

  logic [lpm_width-1:0] b_eff;
  logic [lpm_width:0]   full;

  always_comb begin
    b_eff = add_sub ? ~datab : datab;
    full  = {1'b0, dataa} + {1'b0, b_eff} + {{lpm_width{1'b0}}, cin};
    if (clken && !aclr) begin
      result   = full[lpm_width-1:0];
      cout     = full[lpm_width];
      overflow = (dataa[lpm_width-1] == b_eff[lpm_width-1]) &&
                 (full[lpm_width-1] != dataa[lpm_width-1]);
    end else begin
      result   = '0;
      cout     = 1'b0;
      overflow = 1'b0;
    end
  end

endmodule

// File: rtl/serial_wide_adder.sv
// Multi-cycle wide add/subtract, one CHUNK_W slice per cycle, LSB first.
// Optional macro SERIAL_WIDE_ADDER_BACK_TO_BACK_EN allows accept in DONE.
//
// state | meaning
// IDLE  | waiting for an operand request, in_ready high
// RUN   | stepping slices through the chunk adder, carry chained in carry_q
// DONE  | result held on out_* until the consumer takes it
module serial_wide_adder
  import serial_wide_adder_pkg::*;
#(
  parameter int CHUNK_W = 8,
  parameter int NCHUNKS = 4
) (
  input  logic                       clock,
  input  logic                       aclr_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sub,
  input  logic [CHUNK_W*NCHUNKS-1:0] in_a,
  input  logic [CHUNK_W*NCHUNKS-1:0] in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CHUNK_W*NCHUNKS-1:0] out_sum,
  output logic                       out_cout,
  output logic                       out_ovf
);

  localparam int WIDTH = CHUNK_W * NCHUNKS;
  localparam int IDX_W = idx_width(NCHUNKS);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, b_q, sum_q;
  logic                 carry_q, cout_q, ovf_q;
  logic [IDX_W-1:0]     idx_q;
  logic [CHUNK_W-1:0]   chunk_sum;
  logic                 chunk_cout;
  logic                 accept, last;

  assign accept = in_valid & in_ready;
  assign last   = (idx_q == IDX_W'(NCHUNKS - 1));

  // Operands shift down each RUN cycle, so the active slice is always bits [CHUNK_W-1:0].
  lpm_add_sub #(
    .lpm_width(CHUNK_W)
  ) u_chunk (
    .dataa   (a_q[CHUNK_W-1:0]),
    .datab   (b_q[CHUNK_W-1:0]),
    .cin     (carry_q),
    .add_sub (1'b0),
    .clken   (1'b1),
    .aclr    (1'b0),
    .result  (chunk_sum),
    .cout    (chunk_cout),
    .overflow()
  );

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = RUN;
      RUN:  if (last) state_d = DONE;
      DONE: begin
        if (out_ready) begin
`ifdef SERIAL_WIDE_ADDER_BACK_TO_BACK_EN
          state_d = in_valid ? RUN : IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == DONE);
`ifdef SERIAL_WIDE_ADDER_BACK_TO_BACK_EN
    in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
`else
    in_ready  = (state_q == IDLE);
`endif
  end

  // Result slices enter at the top and settle into place after NCHUNKS shifts.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= in_a;
      b_q     <= in_b ^ {WIDTH{in_sub}};
      carry_q <= in_sub;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> CHUNK_W;
      b_q     <= b_q >> CHUNK_W;
      sum_q   <= (sum_q >> CHUNK_W) | (WIDTH'(chunk_sum) << (WIDTH - CHUNK_W));
      carry_q <= chunk_cout;
      idx_q   <= idx_q + IDX_W'(1);
      if (last) begin
        cout_q <= chunk_cout;
        ovf_q  <= signed_ovf(a_q[CHUNK_W-1], b_q[CHUNK_W-1], chunk_sum[CHUNK_W-1]);
      end
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;
  assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_serial_wide_adder.sv
// Directed bench for serial_wide_adder (CHUNK_W=8, NCHUNKS=4); honours
// SERIAL_WIDE_ADDER_BACK_TO_BACK_EN when the design is built with it.
module tb_serial_wide_adder;

  logic        clock = 1'b0;
  logic        aclr_n;
  logic        in_valid, in_ready, in_sub;
  logic [31:0] in_a, in_b;
  logic        out_valid, out_ready;
  logic [31:0] out_sum;
  logic        out_cout, out_ovf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  serial_wide_adder #(.CHUNK_W(8), .NCHUNKS(4)) dut (
    .clock    (clock),
    .aclr_n   (aclr_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sub   (in_sub),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits for out_valid after an accept edge (sampled #1 after it); returns edges counted.
  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      @(posedge clock);
      #1;
      cycles++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [31:0] e_sum,
                        input logic e_cout, input logic e_ovf);
    int cyc;
    @(negedge clock);
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; out_ready = 1'b0;
    @(posedge clock);
    #1;
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_sub = ~sub;
    check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
    wait_valid(cyc);
    check({tag, "_lat"}, cyc, 32'd4);
    check({tag, "_sum"}, out_sum, e_sum);
    check({tag, "_cout"}, {31'd0, out_cout}, {31'd0, e_cout});
    check({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, e_ovf});
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int cyc;
    aclr_n = 1'b0; in_valid = 1'b0; in_sub = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    #12;
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum", out_sum, 32'd0);
    check("rst_cout", {31'd0, out_cout}, 32'd0);
    check("rst_ovf", {31'd0, out_ovf}, 32'd0);
    @(negedge clock);
    aclr_n = 1'b1;

    run_op("add_ff",   32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0);
    run_op("add_wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
    run_op("sub_brw",  32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    run_op("add_ovf",  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
    run_op("sub_ovf",  32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);

    // Backpressure: result held while out_ready=0 and new requests wait.
    @(negedge clock);
    in_valid = 1'b1; in_a = 32'h00000001; in_b = 32'h00000002; in_sub = 1'b0;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    wait_valid(cyc);
    check("hold_lat", cyc, 32'd4);
    @(negedge clock);
    in_valid = 1'b1; in_a = 32'h00000005; in_b = 32'h00000006;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_sum", out_sum, 32'h00000003);
      check("hold_flags", {30'd0, out_cout, out_ovf}, 32'd0);
      check("hold_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clock);
    out_ready = 1'b1;
`ifdef SERIAL_WIDE_ADDER_BACK_TO_BACK_EN
    @(posedge clock);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_drop", {31'd0, out_valid}, 32'd0);
    check("b2b_busy", {31'd0, in_ready}, 32'd0);
    wait_valid(cyc);
    check("b2b_lat", cyc, 32'd4);
    check("b2b_sum", out_sum, 32'h0000000B);
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check("b2b_idle", {31'd0, in_ready}, 32'd1);
`else
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check("hold_drop", {31'd0, out_valid}, 32'd0);
    check("hold_idle", {31'd0, in_ready}, 32'd1);
`endif

    // Reset during RUN abandons the operation.
    @(negedge clock);
    in_valid = 1'b1; in_a = 32'hAAAAAAAA; in_b = 32'h55555555; in_sub = 1'b0;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    aclr_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_ready", {31'd0, in_ready}, 32'd1);
    check("arst_sum", out_sum, 32'd0);
    @(negedge clock);
    aclr_n = 1'b1;
    repeat (6) begin
      @(posedge clock);
      #1;
      check("arst_quiet", {31'd0, out_valid}, 32'd0);
    end
    run_op("post_rst", 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
